// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: multi-cycle unsigned a - b - bin, DIGIT bits per clock,
// LSB slice first. Optional SUB_SATURATE_EN floors a borrowing result at zero.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid/out_ready   result handshake (result held in DONE)
//   diff                  a - b - bin mod 2^WIDTH (floored at 0 with SUB_SATURATE_EN)
//   borrow_out            1 when a < b + bin
//   zero                  1 when diff == 0
module serial_borrow_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   sub;
    logic [WIDTH-1:0] diff_nx;

    assign in_ready = (state == IDLE);

    // One slice: the top bit of the DIGIT+1 bit difference is the new borrow.
    always_comb begin
        sub = {1'b0, a_q[cnt*DIGIT +: DIGIT]}
            - {1'b0, b_q[cnt*DIGIT +: DIGIT]}
            - {{DIGIT{1'b0}}, br};
        diff_nx = diff;
        diff_nx[cnt*DIGIT +: DIGIT] = sub[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    br   <= sub[DIGIT];
                    diff <= diff_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_out <= sub[DIGIT];
                        out_valid  <= 1'b1;
                        state      <= DONE;
`ifdef SUB_SATURATE_EN
                        if (sub[DIGIT]) begin
                            diff <= '0;
                            zero <= 1'b1;
                        end else begin
                            zero <= (diff_nx == '0);
                        end
`else
                        zero <= (diff_nx == '0);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor: table-driven check of serial_borrow_subtractor
// plus backpressure and mid-operation reset sequences.
module tb_serial_borrow_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        borrow_out;
    logic        zero;

    int total = 0;
    int passed = 0;

    serial_borrow_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Present operands on one edge, then count edges until out_valid.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb,
                            input logic tbin, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ack_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ack_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        vec_t v;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h00000100, 32'h00000000, 1'b1, 32'h000000FF, 1'b0, 1'b0};
        vecs[3] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[8] = '{32'h12345678, 32'h02345678, 1'b0, 32'h10000000, 1'b0, 1'b0};
        vecs[9] = '{32'h00000001, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b1};

        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_borrow", {31'b0, borrow_out}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
`ifdef SUB_SATURATE_EN
            if (v.bo) begin
                v.d = '0;
                v.z = 1'b1;
            end
`endif
            start_op(v.a, v.b, v.bin, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd4);
            chk($sformatf("v%0d_diff", i), diff, v.d);
            chk($sformatf("v%0d_borrow", i), {31'b0, borrow_out}, {31'b0, v.bo});
            chk($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, v.z});
            ack();
        end

        // Backpressure: result held while new operands are offered.
        start_op(32'h00000009, 32'h00000004, 1'b0, lat);
        chk("bp_latency", lat, 32'd4);
        held = diff;
        chk("bp_diff", held, 32'h00000005);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 32'hDEAD0000 + k;
            b = 32'h1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_diff_hold", diff, 32'h00000005);
        end
        ack();
        chk("bp_diff_kept", diff, 32'h00000005);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_accept", {31'b0, in_ready}, 32'd1);
        chk("bp_no_valid", {31'b0, out_valid}, 32'd0);

        // Reset during slice 2.
        @(negedge clk);
        a = 32'hFFFFFFFF;
        b = 32'h00000001;
        bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_diff", diff, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'h0000000A, 32'h00000004, 1'b0, lat);
        chk("post_rst_latency", lat, 32'd4);
        chk("post_rst_diff", diff, 32'h00000006);
        chk("post_rst_borrow", {31'b0, borrow_out}, 32'd0);
        ack();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
